// File: rtl/loop_issuer_pkg.sv
// Shared types and helpers for the loop_issuer two-level sweep sequencer.
package loop_issuer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Terminal index of a loop with the given trip count.
  function automatic int term_idx(input int trip);
    return trip - 1;
  endfunction

endpackage

// File: rtl/loop_issuer_idx_wrap_cnt.sv
// Single-level index counter: counts 0..MAX_VAL, wraps to 0, flags the terminal value.
module idx_wrap_cnt #(
  parameter int              CW      = 16,
  parameter logic [CW-1:0]   MAX_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_clear,
  output logic [CW-1:0] o_value,
  output logic          o_at_max
);

  logic [CW-1:0] r_value;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_inc) begin
      r_value <= o_at_max ? '0 : r_value + CW'(1);
    end
  end

  assign o_value  = r_value;
  assign o_at_max = (r_value == MAX_VAL);

endmodule

// File: rtl/loop_issuer.sv
// Two-level (row, col) loop sequencer with valid/ready beats and a single-cycle done pulse.
module loop_issuer
  import loop_issuer_pkg::*;
#(
  parameter int CW      = 16,
  parameter int ROW_MAX = 4,
  parameter int COL_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clean,
  input  logic          ready,
  output logic          valid,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] ROW_LAST = CW'(term_idx(ROW_MAX));
  localparam logic [CW-1:0] COL_LAST = CW'(term_idx(COL_MAX));

  state_e r_state;
  logic   r_valid;
  logic   r_busy;
  logic   r_done;

  logic w_xfer;
  logic w_last;
  logic w_col_at_max;
  logic w_row_at_max;
  logic w_col_inc;
  logic w_row_inc;
  logic w_clear;

  assign w_xfer    = r_valid & ready;
  assign w_last    = r_valid & w_row_at_max & w_col_at_max;
  // The final beat leaves both indices in place so FIN still shows them.
  assign w_col_inc = w_xfer & ~w_last;
  assign w_row_inc = w_col_inc & w_col_at_max;
  assign w_clear   = clean | (r_state == ST_FIN);

  idx_wrap_cnt #(.CW(CW), .MAX_VAL(COL_LAST)) u_col_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .i_inc    (w_col_inc),
    .i_clear  (w_clear),
    .o_value  (col),
    .o_at_max (w_col_at_max)
  );

  idx_wrap_cnt #(.CW(CW), .MAX_VAL(ROW_LAST)) u_row_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .i_inc    (w_row_inc),
    .i_clear  (w_clear),
    .o_value  (row),
    .o_at_max (w_row_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clean) begin
        // Abort wins over the handshake, so a coinciding last beat never yields done.
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_RUN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_xfer && w_last) begin
              r_state <= ST_FIN;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          ST_FIN: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;
  assign last  = w_last;

endmodule
